// File: rtl/min_max_pkg.sv
// Shared types for the min_max controller: datapath command encoding,
// controller states and the reset command.
package min_max_pkg;

   // Datapath command, driven one-to-one onto the datapath com_i input.
   typedef enum logic [1:0] {
      COM_RANGE  = 2'b00,
      COM_LINEAR = 2'b01,
      COM_OFF    = 2'b10,
      COM_ON     = 2'b11
   } com_t;

   // Controller states; LOAD lasts exactly one cycle.
   typedef enum logic [1:0] {
      OFF,
      LOAD,
      STATIC,
      SWEEP
   } state_t;

   // Command presented after reset: all LEDs dark.
   localparam com_t COM_RESET = COM_OFF;

endpackage

// File: rtl/min_max_tick_div.sv
// Free-running divider: counts 0..DIV-1, flags the terminal count and wraps.
// A synchronous clear restarts the count from zero.
module min_max_tick_div #(
   parameter int unsigned DIV = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tc_o
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == LAST);

   // Next count: clear or wrap at terminal count, otherwise increment.
   always_comb begin
      // NOTE: the default comes first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tc_o) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/min_max_ctrl.sv
// Sequencer for the min_max datapath: accepts and validates configuration
// requests, holds com/min/max/val in registers, generates the blink
// oscillator and optionally sweeps val from min to max.
module min_max_ctrl
   import min_max_pkg::*;
#(
   parameter int unsigned VALSIZE   = 4,
   parameter int unsigned OSC_HALF  = 8,
   parameter int unsigned SWEEP_DIV = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   input  logic [1:0]         cfg_com_i,
   input  logic [VALSIZE-1:0] cfg_min_i,
   input  logic [VALSIZE-1:0] cfg_max_i,
   input  logic [VALSIZE-1:0] cfg_val_i,
   input  logic               cfg_sweep_i,
   output logic [1:0]         com_o,
   output logic [VALSIZE-1:0] min_o,
   output logic [VALSIZE-1:0] max_o,
   output logic [VALSIZE-1:0] val_o,
   output logic               osc_o,
   output logic               err_o,
   output logic               sweep_o
);

   typedef logic [VALSIZE-1:0] val_t;

   // Bounds v into [lo, hi]; used for the sweep start value.
   function automatic val_t clamp(input val_t v, input val_t lo, input val_t hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   state_t state_q, state_d;

   // Captured request, consumed in LOAD. req_sweep_q already folds in com=RANGE.
   com_t req_com_q, req_com_d;
   val_t req_min_q, req_min_d;
   val_t req_max_q, req_max_d;
   val_t req_val_q, req_val_d;
   logic req_sweep_q, req_sweep_d;

   // Registered outputs.
   com_t com_q, com_d;
   val_t min_q, min_d;
   val_t max_q, max_d;
   val_t val_q, val_d;
   logic osc_q, osc_d;
   logic err_q, err_d;
   logic sweep_q, sweep_d;
   logic ready_q, ready_d;

   logic osc_tc, sweep_tc;
   logic accept, reject;

   // Both dividers restart on LOAD so a new configuration starts in phase;
   // the sweep divider is held at zero outside SWEEP.
   min_max_tick_div #(.DIV(OSC_HALF)) u_osc_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (state_q == LOAD),
      .tc_o   (osc_tc)
   );

   min_max_tick_div #(.DIV(SWEEP_DIV)) u_sweep_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (state_q != SWEEP),
      .tc_o   (sweep_tc)
   );

   assign accept = cfg_valid_i && ready_q;
   assign reject = accept && (com_t'(cfg_com_i) == COM_RANGE) && (cfg_min_i > cfg_max_i);

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      req_com_d   = req_com_q;
      req_min_d   = req_min_q;
      req_max_d   = req_max_q;
      req_val_d   = req_val_q;
      req_sweep_d = req_sweep_q;
      com_d       = com_q;
      min_d       = min_q;
      max_d       = max_q;
      val_d       = val_q;
      osc_d       = osc_tc ? ~osc_q : osc_q;
      err_d       = 1'b0;

      unique case (state_q)
         LOAD: begin
            com_d   = req_com_q;
            min_d   = req_min_q;
            max_d   = req_max_q;
            val_d   = req_sweep_q ? clamp(req_val_q, req_min_q, req_max_q) : req_val_q;
            osc_d   = 1'b0;
            state_d = req_sweep_q ? SWEEP : STATIC;
         end
         OFF, STATIC, SWEEP: begin
            if (accept && !reject) begin
               // An accepted request pre-empts any sweep step on this edge.
               req_com_d   = com_t'(cfg_com_i);
               req_min_d   = cfg_min_i;
               req_max_d   = cfg_max_i;
               req_val_d   = cfg_val_i;
               req_sweep_d = cfg_sweep_i && (com_t'(cfg_com_i) == COM_RANGE);
               state_d     = LOAD;
            end else begin
               err_d = reject;
               // Compare before increment so max = all-ones never overflows.
               if (state_q == SWEEP && sweep_tc) begin
                  val_d = (val_q == max_q) ? min_q : val_q + 1'b1;
               end
            end
         end
      endcase

      ready_d = (state_d != LOAD);
      sweep_d = (state_d == SWEEP);
   end

   // State, captured request and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= OFF;
         req_com_q   <= COM_RESET;
         req_min_q   <= '0;
         req_max_q   <= '0;
         req_val_q   <= '0;
         req_sweep_q <= 1'b0;
         com_q       <= COM_RESET;
         min_q       <= '0;
         max_q       <= '0;
         val_q       <= '0;
         osc_q       <= 1'b0;
         err_q       <= 1'b0;
         sweep_q     <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         req_com_q   <= req_com_d;
         req_min_q   <= req_min_d;
         req_max_q   <= req_max_d;
         req_val_q   <= req_val_d;
         req_sweep_q <= req_sweep_d;
         com_q       <= com_d;
         min_q       <= min_d;
         max_q       <= max_d;
         val_q       <= val_d;
         osc_q       <= osc_d;
         err_q       <= err_d;
         sweep_q     <= sweep_d;
         ready_q     <= ready_d;
      end
   end

   assign cfg_ready_o = ready_q;
   assign com_o       = com_q;
   assign min_o       = min_q;
   assign max_o       = max_q;
   assign val_o       = val_q;
   assign osc_o       = osc_q;
   assign err_o       = err_q;
   assign sweep_o     = sweep_q;

endmodule

// File: tb/tb_min_max_ctrl.sv
// Scoreboard bench for min_max_ctrl. The driver steps a time-based reference
// model once per clock edge and queues the expected outputs; the monitor pops
// one entry after every rising edge and compares it against the DUT.
module tb_min_max_ctrl;

   localparam int VS = 4;
   localparam int OH = 8;
   localparam int SD = 16;

   typedef struct packed {
      logic [1:0]    com;
      logic [VS-1:0] mn;
      logic [VS-1:0] mx;
      logic [VS-1:0] vl;
      logic          osc;
      logic          err;
      logic          swp;
      logic          rdy;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cfg_valid_i;
   logic          cfg_ready_o;
   logic [1:0]    cfg_com_i;
   logic [VS-1:0] cfg_min_i, cfg_max_i, cfg_val_i;
   logic          cfg_sweep_i;
   logic [1:0]    com_o;
   logic [VS-1:0] min_o, max_o, val_o;
   logic          osc_o, err_o, sweep_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Reference model state: current datapath values plus elapsed-edge counts
   // from which the oscillator phase and the sweep position are derived.
   int m_com, m_min, m_max, m_val, m_start;
   int m_osc_e, m_sw_e;
   bit m_err, m_swp, m_pend;
   int p_com, p_min, p_max, p_val;
   bit p_sw;

   min_max_ctrl #(.VALSIZE(VS), .OSC_HALF(OH), .SWEEP_DIV(SD)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_com_i   (cfg_com_i),
      .cfg_min_i   (cfg_min_i),
      .cfg_max_i   (cfg_max_i),
      .cfg_val_i   (cfg_val_i),
      .cfg_sweep_i (cfg_sweep_i),
      .com_o       (com_o),
      .min_o       (min_o),
      .max_o       (max_o),
      .val_o       (val_o),
      .osc_o       (osc_o),
      .err_o       (err_o),
      .sweep_o     (sweep_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_com = 2; m_min = 0; m_max = 0; m_val = 0; m_start = 0;
      m_osc_e = 0; m_sw_e = 0;
      m_err = 0; m_swp = 0; m_pend = 0;
   endtask

   // One rising edge of the reference model with the given request inputs.
   task automatic model_step(input bit v, input int c, input int mn, input int mx,
                             input int vl, input bit sw);
      m_err = 0;
      if (m_pend) begin
         m_com = p_com; m_min = p_min; m_max = p_max;
         m_swp = (p_com == 0) && p_sw;
         if (m_swp) m_start = (p_val < p_min) ? p_min : (p_val > p_max) ? p_max : p_val;
         else       m_start = p_val;
         m_val   = m_start;
         m_osc_e = 0;
         m_sw_e  = 0;
         m_pend  = 0;
      end else begin
         m_osc_e++;
         if (v && c == 0 && mn > mx) m_err = 1;
         if (v && !m_err) begin
            m_pend = 1;
            p_com = c; p_min = mn; p_max = mx; p_val = vl; p_sw = sw;
            m_swp = 0;
         end else if (m_swp) begin
            m_sw_e++;
            m_val = m_min + (m_start - m_min + m_sw_e / SD) % (m_max - m_min + 1);
         end
      end
   endtask

   function automatic exp_t cur_exp();
      exp_t e;
      e.com = 2'(m_com);
      e.mn  = VS'(m_min);
      e.mx  = VS'(m_max);
      e.vl  = VS'(m_val);
      e.osc = ((m_osc_e / OH) % 2) == 1;
      e.err = m_err;
      e.swp = m_swp;
      e.rdy = !m_pend;
      return e;
   endfunction

   // Called at a falling edge: drive inputs, predict the next edge, queue it.
   task automatic drive_cycle(input bit v, input int c, input int mn, input int mx,
                              input int vl, input bit sw);
      cfg_valid_i = v;
      cfg_com_i   = 2'(c);
      cfg_min_i   = VS'(mn);
      cfg_max_i   = VS'(mx);
      cfg_val_i   = VS'(vl);
      cfg_sweep_i = sw;
      model_step(v, c, mn, mx, vl, sw);
      exp_q.push_back(cur_exp());
      @(negedge clk_i);
   endtask

   // Idle cycles with random junk on the data inputs and valid low.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_cycle(0, $urandom_range(3), $urandom_range(15), $urandom_range(15),
                     $urandom_range(15), 1'($urandom_range(1)));
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " com"},   int'(com_o),       2);
      check({tag, " min"},   int'(min_o),       0);
      check({tag, " max"},   int'(max_o),       0);
      check({tag, " val"},   int'(val_o),       0);
      check({tag, " osc"},   int'(osc_o),       0);
      check({tag, " err"},   int'(err_o),       0);
      check({tag, " sweep"}, int'(sweep_o),     0);
      check({tag, " ready"}, int'(cfg_ready_o), 1);
   endtask

   // Monitor: compare the DUT against the queued expectation after each edge.
   initial begin
      exp_t e;
      int   cyc = 0;
      forever begin
         @(posedge clk_i);
         #2;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("com@%0d",   cyc), int'(com_o),       int'(e.com));
            check($sformatf("min@%0d",   cyc), int'(min_o),       int'(e.mn));
            check($sformatf("max@%0d",   cyc), int'(max_o),       int'(e.mx));
            check($sformatf("val@%0d",   cyc), int'(val_o),       int'(e.vl));
            check($sformatf("osc@%0d",   cyc), int'(osc_o),       int'(e.osc));
            check($sformatf("err@%0d",   cyc), int'(err_o),       int'(e.err));
            check($sformatf("sweep@%0d", cyc), int'(sweep_o),     int'(e.swp));
            check($sformatf("ready@%0d", cyc), int'(cfg_ready_o), int'(e.rdy));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Driver: directed scenarios, then randomized traffic.
   initial begin
      int guard;
      rst_ni      = 1'b0;
      cfg_valid_i = 1'b0;
      cfg_com_i   = 2'b00;
      cfg_min_i   = '0;
      cfg_max_i   = '0;
      cfg_val_i   = '0;
      cfg_sweep_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      model_reset();
      #1;
      check_reset_values("after reset");

      // Static range configuration; oscillator observed over several periods.
      drive_cycle(1, 0, 3, 8, 5, 0);
      idle(40);

      // min > max with range command is rejected.
      drive_cycle(1, 0, 9, 2, 4, 0);
      idle(3);

      // Sweep near the top of the value range.
      drive_cycle(1, 0, 13, 15, 14, 1);
      idle(70);

      // Degenerate sweep min == max, start value clamped up to 7.
      drive_cycle(1, 0, 7, 7, 3, 1);
      idle(40);

      // Sweep bit with a non-range command is ignored.
      drive_cycle(1, 1, 2, 6, 4, 1);
      idle(5);

      // Accept on the sweep terminal-count edge: no step, osc restarts at 0.
      drive_cycle(1, 0, 13, 15, 14, 1);
      idle(2);
      guard = 0;
      while ((m_sw_e % SD) != SD - 1 && guard < 100) begin
         idle(1);
         guard++;
      end
      check("tc alignment within bound", guard < 100 ? 1 : 0, 1);
      drive_cycle(1, 3, 1, 2, 9, 0);
      idle(20);

      // Reset asserted in the middle of LOAD.
      drive_cycle(1, 0, 2, 12, 6, 0);
      rst_ni = 1'b0;
      #1;
      check_reset_values("reset in LOAD");
      @(negedge clk_i);
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      rst_ni = 1'b1;
      model_reset();
      idle(12);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(29) == 0) begin
            drive_cycle(1, ($urandom_range(1) == 1) ? 0 : $urandom_range(3),
                        $urandom_range(15), $urandom_range(15), $urandom_range(15),
                        1'($urandom_range(3) != 0));
         end else begin
            idle(1);
         end
      end
      idle(2);

      check("scoreboard drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
